// File: rtl/scan_counter_if.sv
// Control, count and display signals of scan_counter, bundled for a single port.
// The master side drives the controls and observes the count and display outputs.
interface scan_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  scan_counter_port_en;
  logic                  scan_counter_port_clr;
  logic                  scan_counter_port_load;
  logic [4*DIGITS-1:0]   scan_counter_port_load_val;
  logic                  scan_counter_port_mode;
  logic                  scan_counter_port_dir;
  logic [4:0]            scan_counter_port_factor;
  logic [DIGITS-1:0]     scan_counter_port_idp;
  logic [4*DIGITS-1:0]   scan_counter_port_value;
  logic                  scan_counter_port_carry;
  logic [6:0]            scan_counter_port_ssd;
  logic                  scan_counter_port_odp;
  logic [7:0]            scan_counter_port_an;

  modport master (
    output scan_counter_port_en,
    output scan_counter_port_clr,
    output scan_counter_port_load,
    output scan_counter_port_load_val,
    output scan_counter_port_mode,
    output scan_counter_port_dir,
    output scan_counter_port_factor,
    output scan_counter_port_idp,
    input  scan_counter_port_value,
    input  scan_counter_port_carry,
    input  scan_counter_port_ssd,
    input  scan_counter_port_odp,
    input  scan_counter_port_an
  );

  modport slave (
    input  scan_counter_port_en,
    input  scan_counter_port_clr,
    input  scan_counter_port_load,
    input  scan_counter_port_load_val,
    input  scan_counter_port_mode,
    input  scan_counter_port_dir,
    input  scan_counter_port_factor,
    input  scan_counter_port_idp,
    output scan_counter_port_value,
    output scan_counter_port_carry,
    output scan_counter_port_ssd,
    output scan_counter_port_odp,
    output scan_counter_port_an
  );
endinterface

// File: rtl/scan_counter.sv
// Multi-digit hex/BCD up/down counter with prescaler, wrap pulse and a
// time-multiplexed active-low seven-segment scan driver.
module scan_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 17
) (
  input  logic          scan_counter_port_clk,
  input  logic          scan_counter_port_rst,
  scan_counter_if.slave bus
);

  localparam int unsigned W        = 4 * DIGITS;
  localparam logic [2:0]  LAST_IDX = 3'(DIGITS - 1);

  logic [31:0]         p_q;
  logic [31:0]         mask;
  logic                tick;
  logic [W-1:0]        value_q;
  logic [W-1:0]        value_nxt;
  logic [W-1:0]        step_val;
  logic                wrap;
  logic                carry_q;
  logic                carry_nxt;
  logic [SCAN_DIV-1:0] refresh_q;
  logic [2:0]          idx_q;
  logic [3:0]          digit_sel;
  logic                dp_sel;
  logic [7:0]          an_c;

  // Up cascade: 9 and illegal digits both roll to 0 and pass the carry on.
  function automatic logic [W:0] bcd_up(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Down cascade: 0 borrows into the next digit; illegal digits settle at 9 without borrowing.
  function automatic logic [W:0] bcd_down(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else if (r[4*i +: 4] > 4'd9) begin
          r[4*i +: 4] = 4'd9;
          b           = 1'b0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b           = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Prescaler compare uses the live factor, so a change applies on the very next edge.
  always_comb begin
    mask = (32'd1 << bus.scan_counter_port_factor) - 32'd1;
    tick = bus.scan_counter_port_en & ((p_q & mask) == mask);
  end

  always_comb begin
    step_val = value_q;
    wrap     = 1'b0;
    if (!bus.scan_counter_port_mode) begin
      if (bus.scan_counter_port_dir) begin
        step_val = value_q + W'(1);
        wrap     = (value_q == '1);
      end else begin
        step_val = value_q - W'(1);
        wrap     = (value_q == '0);
      end
    end else if (bus.scan_counter_port_dir) begin
      {wrap, step_val} = bcd_up(value_q);
    end else begin
      {wrap, step_val} = bcd_down(value_q);
    end
  end

  always_comb begin
    value_nxt = value_q;
    carry_nxt = 1'b0;
    if (bus.scan_counter_port_clr) begin
      value_nxt = '0;
    end else if (bus.scan_counter_port_load) begin
      value_nxt = bus.scan_counter_port_load_val;
    end else if (tick) begin
      value_nxt = step_val;
      carry_nxt = wrap;
    end
  end

  always_ff @(posedge scan_counter_port_clk or negedge scan_counter_port_rst) begin
    if (!scan_counter_port_rst) begin
      p_q     <= '0;
      value_q <= '0;
      carry_q <= 1'b0;
    end else begin
      p_q     <= bus.scan_counter_port_clr ? '0 : p_q + 32'd1;
      value_q <= value_nxt;
      carry_q <= carry_nxt;
    end
  end

  always_ff @(posedge scan_counter_port_clk or negedge scan_counter_port_rst) begin
    if (!scan_counter_port_rst) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else begin
      refresh_q <= refresh_q + SCAN_DIV'(1);
      if (refresh_q == '1) begin
        idx_q <= (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
      end
    end
  end

  // Digit and dp select by compare loop, keeping every slice index constant.
  always_comb begin
    digit_sel = value_q[3:0];
    dp_sel    = bus.scan_counter_port_idp[0];
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        digit_sel = value_q[4*i +: 4];
        dp_sel    = bus.scan_counter_port_idp[i];
      end
    end
  end

  always_comb begin
    an_c        = '1;
    an_c[idx_q] = 1'b0;
  end

  assign bus.scan_counter_port_value = value_q;
  assign bus.scan_counter_port_carry = carry_q;
  assign bus.scan_counter_port_ssd   = glyph(digit_sel);
  assign bus.scan_counter_port_odp   = ~dp_sel;
  assign bus.scan_counter_port_an    = an_c;

endmodule
